decoder_seq: RTL and testbench
==============================

DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter SEL_W, default 3: width of the select index.
REQ-002 Parameter OUT_W, default 8: number of decoded outputs; SHALL satisfy 1 <= OUT_W <= 2**SEL_W, with elaboration failing otherwise.
REQ-003 Parameter SCAN_DIV, default 50_000_000: clock cycles per scan step; SHALL be >= 1.
REQ-004 Parameter ACT_LOW, default 0: 1 inverts every bit of out (active-low outputs).
REQ-005 sys_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-007 mode  in  1  0 = DIRECT (decode in_sel), 1 = SCAN (auto-stepping index).
REQ-008 in_valid  in  1  in_sel is valid this cycle.
REQ-009 in_ready  out  1  combinational; equals (state==DIRECT) && !mode.
REQ-010 in_sel  in  SEL_W  index to decode.
REQ-011 out  out  OUT_W  registered decoded output (one-hot, or one-cold when ACT_LOW=1).
REQ-012 out_valid  out  1  one-cycle pulse marking each out update.
REQ-013 idx  out  SEL_W  registered index currently driving out.
REQ-014 err  out  1  registered; high while the last accepted in_sel was >= OUT_W.

Function
REQ-015 FSM states: ST_DIRECT, ST_SCAN; next state equals mode, sampled every cycle.
REQ-016 DIRECT accept: in_valid && in_ready at edge k SHALL give, at edge k+1, idx=in_sel, out bit in_sel active with all other bits inactive, out_valid=1, and err=0 (latency 1).
REQ-017 DIRECT out-of-range: an accepted in_sel >= OUT_W SHALL set idx=in_sel, drive all out bits inactive, set out_valid=1, and set err=1; err SHALL hold until the next accepted in-range in_sel.
REQ-018 DIRECT with no accept: out, idx and err SHALL hold their values, and out_valid SHALL be 0.
REQ-019 DIRECT->SCAN edge: idx=0, out bit 0 active, out_valid=1, err=0, and divider count=0.
REQ-020 SCAN: the divider counts 0..SCAN_DIV-1; on the terminal count it clears, idx increments, out re-decodes, and out_valid pulses.
REQ-021 SCAN wrap: idx=OUT_W-1 SHALL step to 0, never to an index >= OUT_W.
REQ-022 SCAN_DIV=1: idx SHALL step on every cycle, with out_valid held high continuously.
REQ-023 SCAN: in_ready=0, and in_valid/in_sel are ignored.
REQ-024 SCAN->DIRECT edge: out and idx hold their last scan values, the divider clears, out_valid=0, and acceptance resumes the following cycle.
REQ-025 Simultaneous mode=1 with in_valid=1 in ST_DIRECT: the mode switch wins, and the input is not accepted (in_ready=0).
REQ-026 ACT_LOW is applied at the out register, so out never glitches through the non-inverted value.
REQ-027 No combinational path from inputs to out, idx, out_valid or err.

Reset
REQ-028 sys_rst_n=0 at an edge SHALL set state=ST_DIRECT, idx=0, out bit 0 active (8'h01, or 8'hFE when ACT_LOW=1), out_valid=0, err=0, and divider count=0.
REQ-029 Reset asserted mid-scan or mid-accept SHALL abandon the operation; there are no partial updates after the reset edge.
REQ-030 in_ready SHALL be 0 while sys_rst_n=0.

Structure
REQ-031 Package decoder_pkg SHALL hold the state encodings (ST_DIRECT, ST_SCAN) and the mode constants (MODE_DIRECT=0, MODE_SCAN=1).
REQ-032 The divider SHALL be a sub-module div_cnt (parameter DIV; inputs clr, en; output tc), with width $clog2(SCAN_DIV) minimum 1.
REQ-033 The decode function (index -> OUT_W-bit one-hot, with all bits zero when out of range) SHALL be a single shared function used by both modes.

Verification
REQ-034 Reset then idle (defaults) -> out=8'h01, idx=0, out_valid=0, err=0, in_ready=1.
REQ-035 DIRECT, in_sel=5 with in_valid for 1 cycle -> next cycle out=8'h20, idx=5, single out_valid pulse; out held afterwards.
REQ-036 SEL_W=3, OUT_W=6, in_sel=7 -> out=6'h00, err=1; then in_sel=2 -> out=6'h04, err=0.
REQ-037 SCAN_DIV=4, mode=1 for 40 cycles -> out sequence 01,02,04,...,80,01, with one step every 4 cycles, a pulse per step, and in_ready=0 throughout.
REQ-038 mode=1 and in_valid=1 (in_sel=3) on the same cycle -> no accept; out=8'h01 at the next edge.
REQ-039 Reset asserted at idx=6 mid-scan, ACT_LOW=1 -> out=8'hFE, state=ST_DIRECT, out_valid=0.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_seq shared constants: FSM state encodings and mode values.
package decoder_pkg;

  localparam logic [0:0] ST_DIRECT = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_seq_div_cnt.sv
// Scan-step divider: counts 0..DIV-1 while enabled, tc on the last count.
module div_cnt #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr || tc)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/decoder_seq.sv
// Index decoder with direct (handshaked) and auto-scan modes.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W    = 3,
  parameter int OUT_W    = 8,
  parameter int SCAN_DIV = 50_000_000,
  parameter int ACT_LOW  = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [SEL_W-1:0] idx,
  output logic             err
);

  if (OUT_W < 1 || OUT_W > (1 << SEL_W)) begin : g_bad_out_w
    $error("decoder_seq: OUT_W out of range");
  end
  if (SCAN_DIV < 1) begin : g_bad_div
    $error("decoder_seq: SCAN_DIV must be >= 1");
  end

  localparam logic [OUT_W-1:0] POL  = (ACT_LOW != 0) ? '1 : '0;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(OUT_W - 1);
  localparam logic [SEL_W:0]   LIM  = (SEL_W + 1)'(OUT_W);

  // Out-of-range indices decode to all-inactive.
  function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] s);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int i = 0; i < OUT_W; i++)
      if (int'(s) == i) v[i] = 1'b1;
    return v;
  endfunction

  logic [0:0]       state;
  logic             en;
  logic             clr;
  logic             tc;
  logic [SEL_W-1:0] nxt;

  assign in_ready = sys_rst_n
                 && (state == ST_DIRECT)
                 && (mode == MODE_DIRECT);
  assign en  = (state == ST_SCAN) && (mode == MODE_SCAN);
  assign clr = !en;
  assign nxt = (idx == LAST) ? '0 : idx + 1'b1;

  div_cnt #(
    .DIV (SCAN_DIV)
  ) u_div (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clr   (clr),
    .en    (en),
    .tc    (tc)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= ST_DIRECT;
      idx       <= '0;
      out       <= dec('0) ^ POL;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
      out_valid <= 1'b0;
      unique case (1'b1)
        (state == ST_DIRECT) && (mode == MODE_SCAN): begin
          idx       <= '0;
          out       <= dec('0) ^ POL;
          out_valid <= 1'b1;
          err       <= 1'b0;
        end
        in_ready && in_valid: begin
          idx       <= in_sel;
          out       <= dec(in_sel) ^ POL;
          out_valid <= 1'b1;
          err       <= ({1'b0, in_sel} >= LIM);
        end
        tc: begin
          idx       <= nxt;
          out       <= dec(nxt) ^ POL;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench: three decoder_seq configurations against a behavioural model.
module tb_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       in_valid;
  logic [2:0] in_sel;

  logic [7:0] out_a, out_c;
  logic [5:0] out_b;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       ov_a, ov_b, ov_c;
  logic       er_a, er_b, er_c;
  logic       rd_a, rd_b, rd_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_seq #(.SEL_W(3), .OUT_W(8), .SCAN_DIV(4), .ACT_LOW(0)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_ready(rd_a), .in_sel(in_sel), .out(out_a), .out_valid(ov_a),
    .idx(idx_a), .err(er_a));

  decoder_seq #(.SEL_W(3), .OUT_W(6), .SCAN_DIV(1), .ACT_LOW(0)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_ready(rd_b), .in_sel(in_sel), .out(out_b), .out_valid(ov_b),
    .idx(idx_b), .err(er_b));

  decoder_seq #(.SEL_W(3), .OUT_W(8), .SCAN_DIV(3), .ACT_LOW(1)) dut_c (
    .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_ready(rd_c), .in_sel(in_sel), .out(out_c), .out_valid(ov_c),
    .idx(idx_c), .err(er_c));

  // Model parameters per instance.
  int ow[3] = '{8, 6, 8};
  int dv[3] = '{4, 1, 3};
  int al[3] = '{0, 0, 1};

  // Model state: last sampled mode, plus per-instance index/err/pulse
  // and the number of edges spent in scan since the entry edge.
  bit m_scan;
  int m_idx[3];
  int m_err[3];
  int m_v[3];
  int m_t[3];

  function automatic logic [31:0] exp_out(int k);
    logic [31:0] v;
    logic [31:0] mask;
    v = (m_idx[k] < ow[k]) ? (32'd1 << m_idx[k]) : 32'd0;
    mask = (32'd1 << ow[k]) - 32'd1;
    if (al[k] != 0) v = ~v & mask;
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_idx[k] = 0; m_err[k] = 0; m_v[k] = 0; m_t[k] = 0;
      end else if (!m_scan && mode) begin
        m_idx[k] = 0; m_err[k] = 0; m_v[k] = 1; m_t[k] = 0;
      end else if (!m_scan) begin
        m_v[k] = in_valid;
        if (in_valid) begin
          m_idx[k] = in_sel;
          m_err[k] = (int'(in_sel) >= ow[k]) ? 1 : 0;
        end
      end else if (mode) begin
        m_t[k]++;
        m_v[k] = (m_t[k] % dv[k] == 0) ? 1 : 0;
        if (m_v[k] != 0) m_idx[k] = (m_t[k] / dv[k]) % ow[k];
      end else begin
        m_v[k] = 0;
      end
    end
    m_scan = rst_n ? mode : 1'b0;
  endtask

  function automatic logic [31:0] get(int k, int f);
    logic [31:0] r;
    r = '0;
    case (k)
      0: case (f) 0: r = 32'(out_a); 1: r = 32'(idx_a);
                  2: r = 32'(ov_a);  3: r = 32'(er_a); default: r = 32'(rd_a); endcase
      1: case (f) 0: r = 32'(out_b); 1: r = 32'(idx_b);
                  2: r = 32'(ov_b);  3: r = 32'(er_b); default: r = 32'(rd_b); endcase
      default: case (f) 0: r = 32'(out_c); 1: r = 32'(idx_c);
                  2: r = 32'(ov_c);  3: r = 32'(er_c); default: r = 32'(rd_c); endcase
    endcase
    return r;
  endfunction

  // Apply inputs, check in_ready, clock, update model, check outputs.
  task automatic step(bit r, bit m, bit v, int s);
    rst_n = r; mode = m; in_valid = v; in_sel = 3'(s);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("rdy%0d", k), get(k, 4),
          32'((r && !m_scan && !m) ? 1 : 0));
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out%0d", k), get(k, 0), exp_out(k));
      chk($sformatf("idx%0d", k), get(k, 1), 32'(m_idx[k]));
      chk($sformatf("ov%0d", k),  get(k, 2), 32'(m_v[k]));
      chk($sformatf("err%0d", k), get(k, 3), 32'(m_err[k]));
    end
  endtask

  initial begin
    int n;
    bit rm;
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_sel = '0;
    m_scan = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0; m_err[k] = 0; m_v[k] = 0; m_t[k] = 0;
    end

    step(0, 0, 0, 0);
    step(0, 0, 1, 5);
    step(1, 0, 0, 0);
    chk("rst_out_a", 32'(out_a), 32'h01);
    chk("rst_out_c", 32'(out_c), 32'hFE);
    chk("idle_rdy_a", 32'(rd_a), 32'd1);

    step(1, 0, 1, 5);
    chk("sel5_out_a", 32'(out_a), 32'h20);
    chk("sel5_err_b", 32'(er_b), 32'd0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 2);
    chk("sel5_hold_a", 32'(out_a), 32'h20);

    step(1, 0, 1, 7);
    chk("sel7_out_b", 32'(out_b), 32'h00);
    chk("sel7_err_b", 32'(er_b), 32'd1);
    step(1, 0, 0, 2);
    chk("sel7_errhold_b", 32'(er_b), 32'd1);
    step(1, 0, 1, 2);
    chk("sel2_out_b", 32'(out_b), 32'h04);
    chk("sel2_err_b", 32'(er_b), 32'd0);

    // Mode switch with a simultaneous valid input: switch wins.
    step(1, 1, 1, 3);
    chk("sw_out_a", 32'(out_a), 32'h01);
    for (int i = 0; i < 40; i++) step(1, 1, 1, $urandom_range(0, 7));
    step(1, 0, 0, 0);
    step(1, 0, 1, 4);
    chk("resume_out_a", 32'(out_a), 32'h10);

    // Reset mid-scan once dut_c reaches index 6.
    step(1, 1, 0, 0);
    n = 0;
    while (m_idx[2] != 6 && n < 100) begin
      step(1, 1, 1, 1);
      n++;
    end
    chk("reach_idx6", 32'(idx_c), 32'd6);
    step(0, 1, 1, 3);
    chk("midscan_rst_c", 32'(out_c), 32'hFE);
    chk("midscan_ov_c", 32'(ov_c), 32'd0);

    rm = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) rm = ~rm;
      step(($urandom_range(0, 60) != 0), rm,
           1'($urandom_range(0, 1)), $urandom_range(0, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
